stack8_16: RTL
==============

STACK8_16 -- requirements
Module: stack8_16

Interface
REQ-001 Parameters: none; data width is fixed at 16 bits and depth is fixed at 8 entries.
REQ-002 clock  input  1  Single clock; all state updates on its rising edge.
REQ-003 reset  input  1  Synchronous, active-high; sampled on the rising edge of clock.
REQ-004 push  input  1  Request to write in onto the stack this cycle.
REQ-005 pop  input  1  Request to remove the top entry this cycle.
REQ-006 in  input  16  Data to be pushed.
REQ-007 out  output  16  Current top-of-stack value; 16'h0000 when empty.
REQ-008 count  output  4  Number of valid entries, 0..8.
REQ-009 empty  output  1  High when count==0.
REQ-010 full  output  1  High when count==8.
REQ-011 overflow  output  1  One-cycle pulse when a push was rejected.
REQ-012 underflow  output  1  One-cycle pulse when a pop was rejected.

Function
REQ-013 Storage SHALL be eight 16-bit registers, mem[0..7]; the stack pointer sp (4 bits) SHALL equal count, and the top entry is mem[sp-1].
REQ-014 Write steering SHALL be built from DMux8Way (in = write enable, sel = target index); the top-of-stack read SHALL be built from Mux8Way16 (sel = sp-1, 3 bits).
REQ-015 out, empty, full and count SHALL be combinational from registered state only, with zero added latency: a push at edge N is visible on out immediately after edge N.
REQ-016 Push only, not full: mem[sp] <= in; sp <= sp+1.
REQ-017 Pop only, not empty: sp <= sp-1; memory unchanged.
REQ-018 Push and pop together, not empty (including full): replace top; mem[sp-1] <= in; sp unchanged; no overflow or underflow.
REQ-019 Push and pop together, empty: treated as push only (mem[0] <= in, sp <= 1); no underflow.
REQ-020 Push only while full: ignored (no write, sp stays 8); overflow = 1 for exactly the following cycle.
REQ-021 Pop only while empty: ignored (sp stays 0); underflow = 1 for exactly the following cycle.
REQ-022 Neither push nor pop: state held; overflow = underflow = 0 after the edge.
REQ-023 overflow and underflow SHALL be registered, SHALL never be high together, and SHALL be cleared on the next edge unless re-triggered.
REQ-024 sp SHALL never leave the range 0..8; there is no wrap-around from 8 to 0 or from 0 to 8.
REQ-025 When empty, out SHALL be forced to 16'h0000 regardless of stale memory contents.

Reset
REQ-026 reset=1 at an edge SHALL set sp=0, overflow=0, underflow=0; this gives count=0, empty=1, full=0, out=0.
REQ-027 reset SHALL take priority over push and pop in the same cycle; the request is discarded.
REQ-028 mem[] contents are not cleared by reset; they SHALL be unobservable until rewritten.
REQ-029 Reset asserted mid-sequence (stack partially filled) SHALL produce the REQ-026 state at that edge, with no residual pulses.

Verification
REQ-030 Reset, then push 16'h0001..16'h0008 on consecutive cycles -> count steps 1..8, out tracks the last pushed value, full=1 after the 8th push, overflow stays 0.
REQ-031 From full, push 16'hBEEF -> overflow=1 for one cycle, count=8, out=16'h0008; then pop x8 -> out goes 0007..0001, then 0000 with empty=1.
REQ-032 From empty, pop -> underflow=1 for one cycle, count=0, out=0; pop held two cycles -> underflow high for both cycles.
REQ-033 count=3 (top 16'h0003), push+pop with in=16'hAAAA -> count=3, out=16'hAAAA; repeat at full -> count=8, top replaced, no pulses; push+pop at empty with in=16'h1234 -> count=1, out=16'h1234.
REQ-034 Push 3 entries, then assert reset together with push -> count=0, empty=1, out=0; next push 16'h5555 -> out=16'h5555, count=1.
REQ-035 Random push/pop for 1000 cycles against a reference model -> out, count, empty, full, overflow and underflow match every cycle.

Source files
------------

// File: rtl/stack8_16_if.sv
// stack8_16 request/response bundle.
// Master issues push/pop; slave returns top and status.
interface stack8_16_if;
  logic        push;
  logic        pop;
  logic [15:0] in;
  logic [15:0] out;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  modport master (
    output push, pop, in,
    input  out, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, in,
    output out, count, empty, full,
    output overflow, underflow
  );
endinterface

// File: rtl/stack8_16.sv
// 8-deep x 16-bit LIFO stack with sticky-free
// overflow/underflow pulses and a zero-latency top-of-stack.
module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] o
);
  // one-hot steer of the enable to the selected slot
  always_comb begin
    o      = '0;
    o[sel] = in;
  end
endmodule

module mux8way16 (
  input  logic [7:0][15:0] d,
  input  logic [2:0]       sel,
  output logic [15:0]      o
);
  // pick one of eight words
  always_comb begin
    o = d[sel];
  end
endmodule

module stack8_16 (
  input  logic        clock,
  input  logic        reset,
  stack8_16_if.slave  bus
);
  logic [7:0][15:0] mem;
  logic [3:0]       sp;
  logic [3:0]       spm1;
  logic [3:0]       sp_nxt;
  logic             wen;
  logic [2:0]       widx;
  logic [7:0]       we;
  logic [15:0]      top;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             ovf_q;
  logic             unf_q;
  logic             emp;
  logic             ful;
  logic             rep;
  logic             psh;
  logic             ovr;
  logic             pp;
  logic             unr;

  assign spm1 = sp - 4'd1;
  assign emp  = (sp == 4'd0);
  assign ful  = (sp == 4'd8);

  // mutually exclusive operation classes
  assign rep = bus.push & bus.pop & ~emp;
  assign psh = bus.push & ~rep & ~ful;
  assign ovr = bus.push & ~rep & ful;
  assign pp  = bus.pop & ~bus.push & ~emp;
  assign unr = bus.pop & ~bus.push & emp;

  // next-state and write steering
  always_comb begin
    wen     = 1'b0;
    widx    = sp[2:0];
    sp_nxt  = sp;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    unique case (1'b1)
      rep: begin
        wen  = 1'b1;
        widx = spm1[2:0];
      end
      psh: begin
        wen    = 1'b1;
        sp_nxt = sp + 4'd1;
      end
      ovr: ovf_nxt = 1'b1;
      pp:  sp_nxt  = spm1;
      unr: unf_nxt = 1'b1;
      default: ;
    endcase
  end

  dmux8way u_dmux (
    .in  (wen & ~reset),
    .sel (widx),
    .o   (we)
  );

  mux8way16 u_mux (
    .d   (mem),
    .sel (spm1[2:0]),
    .o   (top)
  );

  // storage; reset leaves contents alone
  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) mem[i] <= bus.in;
    end
  end

  // pointer and one-cycle error pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      sp    <= 4'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp    <= sp_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  assign bus.out       = emp ? 16'h0000 : top;
  assign bus.count     = sp;
  assign bus.empty     = emp;
  assign bus.full      = ful;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
